fnd_scan_decoder: RTL and testbench



---
 rtl/fnd_pkg.sv | 37 +++
 rtl/fnd_font_decoder.sv | 29 ++
 rtl/fnd_scan_decoder.sv | 145 ++++++++++++++
 tb/tb_fnd_scan_decoder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared seven-segment definitions for the display encoder and the scan decoder.
// Select and font codes are active-low, as they appear on the display pins.
package fnd_pkg;

    typedef logic [3:0] bcd_t;

    localparam int unsigned NUM_SLOTS = 4;

    localparam logic [3:0] SEL_ONES      = 4'b1110;
    localparam logic [3:0] SEL_TENS      = 4'b1101;
    localparam logic [3:0] SEL_HUNDREDS  = 4'b1011;
    localparam logic [3:0] SEL_THOUSANDS = 4'b0111;

    // Segment order is bit0=a .. bit6=g; dp is handled outside these codes.
    localparam logic [6:0] FONT_0 = 7'h40;
    localparam logic [6:0] FONT_1 = 7'h79;
    localparam logic [6:0] FONT_2 = 7'h24;
    localparam logic [6:0] FONT_3 = 7'h30;
    localparam logic [6:0] FONT_4 = 7'h19;
    localparam logic [6:0] FONT_5 = 7'h12;
    localparam logic [6:0] FONT_6 = 7'h02;
    localparam logic [6:0] FONT_7 = 7'h78;
    localparam logic [6:0] FONT_8 = 7'h00;
    localparam logic [6:0] FONT_9 = 7'h10;

    // One-hot slot for a legal select code (bit0 = ones); zero for anything else.
    function automatic logic [NUM_SLOTS-1:0] sel_slot(input logic [3:0] sel);
        case (sel)
            SEL_ONES:      sel_slot = 4'b0001;
            SEL_TENS:      sel_slot = 4'b0010;
            SEL_HUNDREDS:  sel_slot = 4'b0100;
            SEL_THOUSANDS: sel_slot = 4'b1000;
            default:       sel_slot = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/fnd_font_decoder.sv
// Maps a 7-bit active-low segment pattern back to its BCD digit.
// Patterns outside the shared font table are flagged invalid and decode to 0.
module fnd_font_decoder
    import fnd_pkg::*;
(
    input  logic [6:0] font_i,
    output bcd_t       digit_o,
    output logic       invalid_o
);

    always_comb begin
        digit_o   = 4'd0;
        invalid_o = 1'b0;
        case (font_i)
            FONT_0:  digit_o = 4'd0;
            FONT_1:  digit_o = 4'd1;
            FONT_2:  digit_o = 4'd2;
            FONT_3:  digit_o = 4'd3;
            FONT_4:  digit_o = 4'd4;
            FONT_5:  digit_o = 4'd5;
            FONT_6:  digit_o = 4'd6;
            FONT_7:  digit_o = 4'd7;
            FONT_8:  digit_o = 4'd8;
            FONT_9:  digit_o = 4'd9;
            default: invalid_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Rebuilds the 4-digit number shown on a scanned seven-segment bus.
// Each slot is captured once its lines have held steady; a full frame yields one value.
module fnd_scan_decoder
    import fnd_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [3:0]  i_fndSelect,
    input  logic [7:0]  i_fndFont,
    output logic [13:0] o_value,
    output logic        o_valid,
    output logic        o_error,
    output logic [15:0] o_digits
);

    localparam logic [7:0] SettleMax  = 8'(SETTLE_CYCLES);
    localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);

    logic [11:0] pair_s;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign pair_s = {i_fndSelect, i_fndFont};
    end else begin : g_sync
        logic [11:0] sync_q [SYNC_STAGES];

        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                for (int i = 0; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= '1;
                end
            end else begin
                sync_q[0] <= {i_fndSelect, i_fndFont};
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_q[i] <= sync_q[i-1];
                end
            end
        end

        assign pair_s = sync_q[SYNC_STAGES-1];
    end

    logic [11:0]        prev_q;
    logic [7:0]         cnt_q, cnt_d;
    logic               dwell_q, dwell_d;
    logic               same;
    logic               capture;
    logic [3:0]         slot_hot;
    bcd_t               font_digit;
    logic               font_invalid;

    bcd_t [3:0]         digit_q, digit_d;
    logic [3:0]         err_q, err_d;
    logic [3:0]         mask_q, mask_d;
    logic               frame_done;

    logic [13:0]        value_q, value_asm;
    logic [15:0]        digits_q;
    logic               error_q, valid_q;

    fnd_font_decoder u_font_dec (
        .font_i    (pair_s[6:0]),
        .digit_o   (font_digit),
        .invalid_o (font_invalid)
    );

    assign same       = (pair_s == prev_q);
    assign slot_hot   = sel_slot(pair_s[11:8]);
    assign frame_done = (mask_q == 4'hF);

    // cnt_d is the run length seen this cycle; the capture fires on the value it reaches now.
    always_comb begin
        cnt_d = 8'd0;
        if (same) begin
            cnt_d = (cnt_q == SettleMax) ? cnt_q : cnt_q + 8'd1;
        end
        capture = (cnt_d == SettleLast) && !(same && dwell_q) && (slot_hot != 4'b0000);
        dwell_d = capture || (same && dwell_q);
    end

    // A capture in the frame-clear cycle lands in the fresh frame.
    always_comb begin
        digit_d = digit_q;
        err_d   = frame_done ? 4'b0000 : err_q;
        mask_d  = frame_done ? 4'b0000 : mask_q;
        if (capture) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (slot_hot[i]) begin
                    digit_d[i] = font_invalid ? 4'd0 : font_digit;
                    err_d[i]   = font_invalid;
                    mask_d[i]  = 1'b1;
                end
            end
        end
    end

    // x1000 = 512+256+128+64+32+8, x100 = 64+32+4, x10 = 8+2.
    always_comb begin
        logic [13:0] d3, d2, d1, d0;
        d3 = 14'(digit_q[3]);
        d2 = 14'(digit_q[2]);
        d1 = 14'(digit_q[1]);
        d0 = 14'(digit_q[0]);
        value_asm = (d3 << 9) + (d3 << 8) + (d3 << 7) + (d3 << 6) + (d3 << 5) + (d3 << 3)
                  + (d2 << 6) + (d2 << 5) + (d2 << 2)
                  + (d1 << 3) + (d1 << 1)
                  + d0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prev_q   <= '1;
            cnt_q    <= 8'd0;
            dwell_q  <= 1'b0;
            digit_q  <= '0;
            err_q    <= 4'b0000;
            mask_q   <= 4'b0000;
            value_q  <= 14'd0;
            digits_q <= 16'h0000;
            error_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            prev_q  <= pair_s;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            digit_q <= digit_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            valid_q <= frame_done;
            if (frame_done) begin
                value_q  <= value_asm;
                digits_q <= digit_q;
                error_q  <= |err_q;
            end
        end
    end

    assign o_value  = value_q;
    assign o_valid  = valid_q;
    assign o_error  = error_q;
    assign o_digits = digits_q;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Bench for fnd_scan_decoder: directed and random dwell sequences scored against a
// dwell-level model that predicts each frame's value and the cycle of its valid pulse.
module tb_fnd_scan_decoder;

    localparam int SYNC   = 2;
    localparam int SETTLE = 4;
    localparam int MAXC   = 8192;

    localparam logic [6:0] FONT_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [3:0] SEL_CODE [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    localparam logic [3:0] BLANK_SEL     = 4'hF;
    localparam logic [7:0] BLANK_FONT    = 8'hFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sel;
    logic [7:0]  font;
    logic [13:0] value;
    logic        valid;
    logic        error;
    logic [15:0] digits;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int ncyc  = 0;

    logic [3:0] dw_sel  [$];
    logic [7:0] dw_font [$];
    int         dw_len  [$];
    bit         dw_rst  [$];

    logic [3:0]  c_sel     [MAXC];
    logic [7:0]  c_font    [MAXC];
    bit          c_rst     [MAXC];
    bit          ev_rst    [MAXC];
    bit          ev_valid  [MAXC];
    int          ev_value  [MAXC];
    logic [15:0] ev_digits [MAXC];
    bit          ev_err    [MAXC];

    fnd_scan_decoder #(
        .SYNC_STAGES   (SYNC),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_fndSelect (sel),
        .i_fndFont   (font),
        .o_value     (value),
        .o_valid     (valid),
        .o_error     (error),
        .o_digits    (digits)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Back-to-back dwells with an identical pair are one dwell on the bus.
    task automatic add_dwell(input logic [3:0] s, input logic [7:0] f, input int len,
                             input bit r);
        int last;
        last = dw_len.size() - 1;
        if (last >= 0 && dw_sel[last] == s && dw_font[last] == f && dw_rst[last] == r) begin
            dw_len[last] = dw_len[last] + len;
        end else begin
            dw_sel.push_back(s);
            dw_font.push_back(f);
            dw_len.push_back(len);
            dw_rst.push_back(r);
        end
    endtask

    task automatic add_digit(input int slot, input int d, input int len);
        add_dwell(SEL_CODE[slot], {1'b1, FONT_TAB[d]}, len, 1'b0);
    endtask

    task automatic add_reset(input int len);
        add_dwell(BLANK_SEL, BLANK_FONT, 8, 1'b0);
        add_dwell(BLANK_SEL, BLANK_FONT, len, 1'b1);
    endtask

    function automatic int font_digit(input logic [6:0] f);
        for (int d = 0; d < 10; d++) begin
            if (FONT_TAB[d] == f) return d;
        end
        return -1;
    endfunction

    function automatic int slot_of(input logic [3:0] s);
        for (int i = 0; i < 4; i++) begin
            if (SEL_CODE[i] == s) return i;
        end
        return -1;
    endfunction

    task automatic build_stimulus();
        add_dwell(BLANK_SEL, BLANK_FONT, 3, 1'b1);
        // Two slots, then reset: the partial frame must vanish; then 4321.
        add_digit(0, 1, 10);
        add_digit(1, 2, 10);
        add_reset(3);
        add_digit(0, 1, 10);
        add_digit(1, 2, 10);
        add_digit(2, 3, 10);
        add_digit(3, 4, 10);
        for (int i = 0; i < 4; i++) add_digit(i, 9, 10);
        // Blank thousands pattern gives an errored frame reading 12.
        add_digit(0, 2, 8);
        add_digit(1, 1, 8);
        add_digit(2, 0, 8);
        add_dwell(SEL_CODE[3], 8'hFF, 8, 1'b0);
        // Dwells one cycle short of settling never capture.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) add_digit(i, int'($urandom_range(0, 9)), SETTLE - 1);
        end
        add_dwell(BLANK_SEL, BLANK_FONT, 5, 1'b0);
        // Illegal selects between legal dwells: 0705.
        add_digit(3, 0, 10);
        add_dwell(BLANK_SEL, {1'b1, FONT_TAB[8]}, 6, 1'b0);
        add_digit(2, 7, 10);
        add_dwell(4'b1100, {1'b1, FONT_TAB[3]}, 6, 1'b0);
        add_digit(1, 0, 10);
        add_dwell(4'b0000, {1'b1, FONT_TAB[1]}, 6, 1'b0);
        add_digit(0, 5, 10);
        // 2024 three times with random dp.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                int d;
                d = (i == 0) ? 4 : (i == 1) ? 2 : (i == 2) ? 0 : 2;
                add_dwell(SEL_CODE[i], {1'($urandom_range(0, 1)), FONT_TAB[d]}, 6, 1'b0);
            end
        end
        for (int n = 0; n < 300; n++) begin
            int         r;
            logic [3:0] s;
            logic [7:0] f;
            r = int'($urandom_range(0, 9));
            if (r < 7)       s = SEL_CODE[$urandom_range(0, 3)];
            else if (r == 7) s = BLANK_SEL;
            else if (r == 8) s = 4'h0;
            else             s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) f = 8'($urandom_range(0, 255));
            else                           f = {1'($urandom_range(0, 1)),
                                                FONT_TAB[$urandom_range(0, 9)]};
            add_dwell(s, f, int'($urandom_range(1, 12)), 1'b0);
            if ($urandom_range(0, 39) == 0) add_reset(2);
        end
        add_dwell(BLANK_SEL, BLANK_FONT, 16, 1'b0);
    endtask

    // Frame-level model: a dwell of SETTLE or more cycles on a legal select fills its slot;
    // its pair reaches the counter SYNC cycles late and the pulse follows two cycles
    // after the capturing sample.
    task automatic build_model();
        int c;
        int dig [4];
        bit er  [4];
        bit have[4];
        c = 0;
        for (int i = 0; i < MAXC; i++) begin
            ev_rst[i]   = 1'b0;
            ev_valid[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            dig[i]  = 0;
            er[i]   = 1'b0;
            have[i] = 1'b0;
        end
        for (int i = 0; i < dw_len.size(); i++) begin
            int slot;
            if (c + dw_len[i] > MAXC - 16) break;
            for (int k = 0; k < dw_len[i]; k++) begin
                c_sel[c+k]  = dw_sel[i];
                c_font[c+k] = dw_font[i];
                c_rst[c+k]  = dw_rst[i];
                if (dw_rst[i]) ev_rst[c+k+1] = 1'b1;
            end
            slot = slot_of(dw_sel[i]);
            if (dw_rst[i]) begin
                for (int j = 0; j < 4; j++) have[j] = 1'b0;
            end else if (dw_len[i] >= SETTLE && slot >= 0) begin
                int d;
                int cap;
                cap        = c + SYNC + SETTLE - 1;
                d          = font_digit(dw_font[i][6:0]);
                dig[slot]  = (d < 0) ? 0 : d;
                er[slot]   = (d < 0);
                have[slot] = 1'b1;
                if (have[0] && have[1] && have[2] && have[3]) begin
                    ev_valid[cap+2]  = 1'b1;
                    ev_value[cap+2]  = dig[3] * 1000 + dig[2] * 100 + dig[1] * 10 + dig[0];
                    ev_digits[cap+2] = 16'(dig[3] * 4096 + dig[2] * 256 + dig[1] * 16 + dig[0]);
                    ev_err[cap+2]    = er[0] | er[1] | er[2] | er[3];
                    for (int j = 0; j < 4; j++) have[j] = 1'b0;
                end
            end
            c = c + dw_len[i];
        end
        ncyc = c;
    endtask

    initial begin
        int          exp_value;
        logic [15:0] exp_digits;
        bit          exp_err;
        bit          exp_valid;
        build_stimulus();
        build_model();
        exp_value  = 0;
        exp_digits = 16'h0000;
        exp_err    = 1'b0;
        rst  = c_rst[0];
        sel  = c_sel[0];
        font = c_font[0];
        for (int c = 1; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            cyc       = c;
            exp_valid = 1'b0;
            if (ev_rst[c]) begin
                exp_value  = 0;
                exp_digits = 16'h0000;
                exp_err    = 1'b0;
            end else if (ev_valid[c]) begin
                exp_valid  = 1'b1;
                exp_value  = ev_value[c];
                exp_digits = ev_digits[c];
                exp_err    = ev_err[c];
            end
            check("valid", 16'(valid), 16'(exp_valid));
            check("value", 16'(value), 16'(exp_value));
            check("digits", digits, exp_digits);
            check("error", 16'(error), 16'(exp_err));
            rst  = c_rst[c];
            sel  = c_sel[c];
            font = c_font[c];
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
